// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern engine: mode codes, bounce direction
// and the per-mode pattern loaded on a mode change.
package led_seq_pkg;

    localparam logic [1:0] MODE_BLINK  = 2'd0;
    localparam logic [1:0] MODE_SHIFT  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Returned wide; callers truncate to their LED count.
    function automatic logic [31:0] init_pattern(input logic [1:0] m);
        return (m == MODE_SHIFT || m == MODE_BOUNCE) ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Runtime-programmable prescaler: one-cycle tick every period+1 enabled
// cycles, with a synchronous clear that also suppresses a coincident tick.
module tick_prescaler
    import led_seq_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                clear,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt;

    assign tick = enable && !clear && (cnt == period);

    // cnt above a freshly lowered period restarts at 0 rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt >= period) cnt <= '0;
            else               cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern engine: advances one of four patterns on each prescaler tick
// and drives the LED pins with selectable polarity, all in the clk domain.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int LEDS_NR        = 6,
    parameter int PERIOD_W       = 24,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic [1:0]          mode,
    output logic [LEDS_NR-1:0]  led,
    output logic                step
);

    localparam logic [LEDS_NR-1:0] ONE = LEDS_NR'(1);

    logic [1:0]         mode_q;
    dir_t               dir;
    dir_t               next_dir;
    logic [LEDS_NR-1:0] pattern;
    logic [LEDS_NR-1:0] next_pat;
    logic               mode_change;
    logic               tick;

    assign mode_change = (mode != mode_q);

    tick_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .period (period),
        .clear  (mode_change),
        .tick   (tick)
    );

    always_comb begin
        next_pat = pattern;
        next_dir = dir;
        case (mode_q)
            MODE_BLINK: next_pat = ~pattern;
            MODE_SHIFT: begin
                if (pattern == '0) next_pat = ONE;
                else               next_pat = (pattern << 1) | (pattern >> (LEDS_NR - 1));
            end
            MODE_BOUNCE: begin
                // Endpoints turn around immediately so they are never shown twice.
                if (pattern == '0 || LEDS_NR == 1) begin
                    next_pat = ONE;
                    next_dir = DIR_UP;
                end else if (dir == DIR_UP) begin
                    if (pattern[LEDS_NR-1]) begin
                        next_pat = pattern >> 1;
                        next_dir = DIR_DOWN;
                    end else begin
                        next_pat = pattern << 1;
                    end
                end else begin
                    if (pattern[0]) begin
                        next_pat = pattern << 1;
                        next_dir = DIR_UP;
                    end else begin
                        next_pat = pattern >> 1;
                    end
                end
            end
            default: next_pat = pattern + ONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_BLINK;
            dir     <= DIR_UP;
            pattern <= '0;
            step    <= 1'b0;
        end else begin
            mode_q <= mode;
            step   <= 1'b0;
            if (mode_change) begin
                pattern <= LEDS_NR'(init_pattern(mode));
                dir     <= DIR_UP;
            end else if (tick) begin
                pattern <= next_pat;
                dir     <= next_dir;
                step    <= 1'b1;
            end
        end
    end

    assign led = pattern ^ {LEDS_NR{LED_ACTIVE_LOW}};

endmodule
